// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI transfer supervisor.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } xfer_state_t;

  localparam int STATS_W = 8;
  localparam logic [STATS_W-1:0] STATS_SAT = 8'd255;

  // Saturating increment for the timeout event counter.
  function automatic logic [STATS_W-1:0] stats_sat_inc(input logic [STATS_W-1:0] val);
    if (val == STATS_SAT) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

endpackage

// File: rtl/xfer_timer.sv
// Down-counting attempt timer: loads on strobe, counts down to zero while enabled.
module xfer_timer #(
  parameter int N = 4
) (
  input  logic         i_clk_p,
  input  logic         i_rst_n,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [N-1:0] cnt_r;

  // Counter register: load has priority over decrement, and it stops at zero.
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != '0)) begin
      cnt_r <= cnt_r - N'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/spi_xfer_supervisor.sv
// Sequences SPI transfers with per-attempt timeout, abort and bounded retry.
// Optional timeout statistics counter is compiled in when SPI_XFER_STATS_EN is defined.
module spi_xfer_supervisor
  import spi_ctrl_pkg::*;
#(
  parameter int N       = 4,
  parameter int RETRY_W = 2
) (
  input  logic               i_clk_p,
  input  logic               i_rst_n,
  input  logic               i_cfg_we,
  input  logic [N-1:0]       i_cfg_cycles,
  input  logic [RETRY_W-1:0] i_cfg_retries,
  input  logic               i_req,
  output logic               o_ack,
  output logic               o_spi_start,
  input  logic               i_spi_done,
  output logic               o_spi_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fail,
  output logic [RETRY_W-1:0] o_retry_cnt,
  output logic [STATS_W-1:0] o_timeouts
);

  xfer_state_t        state_r;
  xfer_state_t        next_state_s;
  logic [N-1:0]       cfg_cycles_r;
  logic [RETRY_W-1:0] cfg_retries_r;
  logic [RETRY_W-1:0] retry_cnt_r;
  logic [RETRY_W-1:0] retry_cnt_nxt_s;
  logic               cfg_wr_s;
  logic               timer_load_s;
  logic               timer_en_s;
  logic               timer_zero_s;
  logic               ack_r;
  logic               start_r;
  logic               abort_r;
  logic               busy_r;
  logic               done_r;
  logic               fail_r;

  assign cfg_wr_s     = (state_r == ST_IDLE) && i_cfg_we;
  assign timer_load_s = (state_r == ST_START);
  assign timer_en_s   = (state_r == ST_WAIT);

  xfer_timer #(
    .N (N)
  ) u_timer (
    .i_clk_p  (i_clk_p),
    .i_rst_n  (i_rst_n),
    .load     (timer_load_s),
    .load_val (cfg_cycles_r),
    .en       (timer_en_s),
    .zero     (timer_zero_s)
  );

  // Next-state and retry-count logic; a done in WAIT beats a coincident expiry.
  always_comb begin
    next_state_s    = state_r;
    retry_cnt_nxt_s = retry_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req) begin
          next_state_s    = ST_START;
          retry_cnt_nxt_s = '0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (i_spi_done) begin
          next_state_s = ST_DONE;
        end else if (timer_zero_s && (cfg_cycles_r != '0)) begin
          next_state_s = ST_ABORT;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_ABORT: begin
        if (retry_cnt_r < cfg_retries_r) begin
          next_state_s    = ST_START;
          retry_cnt_nxt_s = retry_cnt_r + RETRY_W'(1);
        end else begin
          next_state_s = ST_FAIL;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      ST_FAIL: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, retry count and output flops; outputs are decoded from the upcoming state.
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      retry_cnt_r <= '0;
      ack_r       <= 1'b0;
      start_r     <= 1'b0;
      abort_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      retry_cnt_r <= retry_cnt_nxt_s;
      ack_r       <= (next_state_s == ST_START) && (retry_cnt_nxt_s == '0);
      start_r     <= (next_state_s == ST_START);
      abort_r     <= (next_state_s == ST_ABORT);
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      fail_r      <= (next_state_s == ST_FAIL);
    end
  end

  // Config latch; only open in IDLE so a running transfer keeps its C and R.
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      cfg_cycles_r  <= '0;
      cfg_retries_r <= '0;
    end else if (cfg_wr_s) begin
      cfg_cycles_r  <= i_cfg_cycles;
      cfg_retries_r <= i_cfg_retries;
    end else begin
      cfg_cycles_r  <= cfg_cycles_r;
      cfg_retries_r <= cfg_retries_r;
    end
  end

`ifdef SPI_XFER_STATS_EN
  logic [STATS_W-1:0] timeouts_r;

  // Timeout event counter, bumped on each ABORT entry and cleared by a config write.
  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      timeouts_r <= '0;
    end else if (cfg_wr_s) begin
      timeouts_r <= '0;
    end else if ((next_state_s == ST_ABORT) && (state_r != ST_ABORT)) begin
      timeouts_r <= stats_sat_inc(timeouts_r);
    end else begin
      timeouts_r <= timeouts_r;
    end
  end

  assign o_timeouts = timeouts_r;
`else
  assign o_timeouts = '0;
`endif

  assign o_ack       = ack_r;
  assign o_spi_start = start_r;
  assign o_spi_abort = abort_r;
  assign o_busy      = busy_r;
  assign o_done      = done_r;
  assign o_fail      = fail_r;
  assign o_retry_cnt = retry_cnt_r;

endmodule

// File: tb/tb_spi_xfer_supervisor.sv
// Directed table-driven bench for spi_xfer_supervisor plus hand-written corner sequences.
module tb_spi_xfer_supervisor;

`ifdef SPI_XFER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int NVEC = 37;

  typedef struct {
    logic        we;
    logic [3:0]  cyc;
    logic [1:0]  ret;
    logic        req;
    logic        dn;
    logic [15:0] exp;
  } vec_t;

  logic       i_clk_p = 1'b0;
  logic       i_rst_n;
  logic       i_cfg_we;
  logic [3:0] i_cfg_cycles;
  logic [1:0] i_cfg_retries;
  logic       i_req;
  logic       i_spi_done;
  logic       o_ack, o_spi_start, o_spi_abort, o_busy, o_done, o_fail;
  logic [1:0] o_retry_cnt;
  logic [7:0] o_timeouts;

  int errors = 0;
  int checks = 0;
  vec_t tbl [NVEC];

  spi_xfer_supervisor #(.N(4), .RETRY_W(2)) dut (
    .i_clk_p       (i_clk_p),
    .i_rst_n       (i_rst_n),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_cycles  (i_cfg_cycles),
    .i_cfg_retries (i_cfg_retries),
    .i_req         (i_req),
    .o_ack         (o_ack),
    .o_spi_start   (o_spi_start),
    .i_spi_done    (i_spi_done),
    .o_spi_abort   (o_spi_abort),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_fail        (o_fail),
    .o_retry_cnt   (o_retry_cnt),
    .o_timeouts    (o_timeouts)
  );

  always #5 i_clk_p = ~i_clk_p;

  // Expected output word {ack,start,abort,busy,done,fail,retry_cnt,timeouts}.
  function automatic logic [15:0] e(int a, int s, int ab, int b, int d, int f, int rc, int to);
    logic [7:0] to_v;
    to_v = STATS_ON ? to[7:0] : 8'd0;
    return {a[0], s[0], ab[0], b[0], d[0], f[0], rc[1:0], to_v};
  endfunction

  function automatic vec_t v(int we, int cyc, int ret, int req, int dn, logic [15:0] exp);
    vec_t r;
    r.we  = we[0];
    r.cyc = cyc[3:0];
    r.ret = ret[1:0];
    r.req = req[0];
    r.dn  = dn[0];
    r.exp = exp;
    return r;
  endfunction

  task automatic drive(input logic we, input logic [3:0] cyc, input logic [1:0] ret,
                       input logic req, input logic dn);
    i_cfg_we      = we;
    i_cfg_cycles  = cyc;
    i_cfg_retries = ret;
    i_req         = req;
    i_spi_done    = dn;
  endtask

  task automatic step();
    @(posedge i_clk_p);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {o_ack, o_spi_start, o_spi_abort, o_busy, o_done, o_fail, o_retry_cnt, o_timeouts};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Cycle t inputs -> expected outputs during cycle t+1.
    // A: C=3 R=0 (config with req), done at t=4; cfg_we in WAIT ignored.
    tbl[0]  = v(1, 3, 0, 1, 0, e(1, 1, 0, 1, 0, 0, 0, 0));
    tbl[1]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[2]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[3]  = v(1, 7, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[4]  = v(0, 0, 0, 0, 1, e(0, 0, 0, 1, 1, 0, 0, 0));
    tbl[5]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0));
    // Next transaction still uses C=3, R=0: abort at 12, fail at 13; req held across it.
    tbl[6]  = v(0, 0, 0, 1, 0, e(1, 1, 0, 1, 0, 0, 0, 0));
    tbl[7]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[8]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[9]  = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[10] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[11] = v(0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0, 1));
    tbl[12] = v(0, 0, 0, 1, 0, e(0, 0, 0, 1, 0, 1, 0, 1));
    tbl[13] = v(0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 1));
    // B: C=3 R=1 from t=14, no done: aborts at 20 and 26, retry start at 21, fail at 27.
    tbl[14] = v(1, 3, 1, 1, 0, e(1, 1, 0, 1, 0, 0, 0, 0));
    tbl[15] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[16] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[17] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[18] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[19] = v(0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 0, 1));
    tbl[20] = v(0, 0, 0, 0, 0, e(0, 1, 0, 1, 0, 0, 1, 1));
    tbl[21] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 1, 1));
    tbl[22] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 1, 1));
    tbl[23] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 1, 1));
    tbl[24] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 1, 1));
    tbl[25] = v(0, 0, 0, 0, 0, e(0, 0, 1, 1, 0, 0, 1, 2));
    tbl[26] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 1, 1, 2));
    tbl[27] = v(0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 1, 2));
    tbl[28] = v(0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 1, 2));
    // C: C=3 R=0 from t=29, done and expiry together at t=34 -> done at 35, no abort.
    tbl[29] = v(1, 3, 0, 1, 0, e(1, 1, 0, 1, 0, 0, 0, 0));
    tbl[30] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[31] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[32] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[33] = v(0, 0, 0, 0, 0, e(0, 0, 0, 1, 0, 0, 0, 0));
    tbl[34] = v(0, 0, 0, 0, 1, e(0, 0, 0, 1, 1, 0, 0, 0));
    tbl[35] = v(0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0));
    tbl[36] = v(0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, 0, 0, 0));

    i_rst_n = 1'b0;
    drive(1'b0, 4'd0, 2'd0, 1'b0, 1'b0);
    step();
    step();
    check("reset_state", e(0, 0, 0, 0, 0, 0, 0, 0));
    i_rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("idle_%0d", k), e(0, 0, 0, 0, 0, 0, 0, 0));
    end

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].we, tbl[i].cyc, tbl[i].ret, tbl[i].req, tbl[i].dn);
      step();
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // C=0 disables the timeout: done at t=40 -> o_done at 41, never an abort.
    for (int k = 0; k <= 41; k++) begin
      drive(k == 0, 4'd0, 2'd0, k == 0, k == 40);
      step();
      if (k == 0) begin
        check("c0_start", e(1, 1, 0, 1, 0, 0, 0, 0));
      end else if (k < 40) begin
        check($sformatf("c0_wait_%0d", k + 1), e(0, 0, 0, 1, 0, 0, 0, 0));
      end else if (k == 40) begin
        check("c0_done", e(0, 0, 0, 1, 1, 0, 0, 0));
      end else begin
        check("c0_idle", e(0, 0, 0, 0, 0, 0, 0, 0));
      end
    end

    // Reset during WAIT of the second attempt (C=3 R=1): everything clears, no abort.
    for (int k = 0; k <= 9; k++) begin
      drive(k == 0, 4'd3, 2'd1, k == 0, 1'b0);
      i_rst_n = (k == 9) ? 1'b0 : 1'b1;
      step();
      if (k == 0) begin
        check("rst_seq_start", e(1, 1, 0, 1, 0, 0, 0, 0));
      end else if (k == 5) begin
        check("rst_seq_abort", e(0, 0, 1, 1, 0, 0, 0, 1));
      end else if (k == 6) begin
        check("rst_seq_retry", e(0, 1, 0, 1, 0, 0, 1, 1));
      end else if (k == 9) begin
        check("rst_seq_cleared", e(0, 0, 0, 0, 0, 0, 0, 0));
      end else if (k < 5) begin
        check($sformatf("rst_seq_wait1_%0d", k + 1), e(0, 0, 0, 1, 0, 0, 0, 0));
      end else begin
        check($sformatf("rst_seq_wait2_%0d", k + 1), e(0, 0, 0, 1, 0, 0, 1, 1));
      end
    end
    i_rst_n = 1'b1;
    drive(1'b0, 4'd0, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("post_rst_idle_%0d", k), e(0, 0, 0, 0, 0, 0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_xfer_supervisor.md
# spi_xfer_supervisor

Transaction supervisor for the SPI master: accepts transfer requests, starts the SPI core, and guards each transfer with a programmable timeout. On timeout it aborts and retries up to a configured limit, then reports success or failure. It is the sequencing layer between the register/requester side and the SPI core's start/done/abort controls.

## Interface
- N, 4: timeout counter width
- RETRY_W, 2: retry counter width
- i_clk_p  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_cfg_we  in  1  config write strobe, accepted in IDLE only
- i_cfg_cycles  in  N  timeout value C; 0 disables the timeout
- i_cfg_retries  in  RETRY_W  max retries R after first attempt
- i_req  in  1  transfer request, level, sampled in IDLE
- o_ack  out  1  one-cycle pulse: request accepted
- o_spi_start  out  1  one-cycle pulse to SPI core per attempt
- i_spi_done  in  1  SPI core completion pulse
- o_spi_abort  out  1  one-cycle pulse to SPI core on timeout
- o_busy  out  1  high whenever state is not IDLE
- o_done  out  1  one-cycle pulse: transfer succeeded
- o_fail  out  1  one-cycle pulse: retries exhausted
- o_retry_cnt  out  RETRY_W  retries used in current/last transaction
- o_timeouts  out  8  saturating timeout event count (see Configuration)

## Operation
- States: IDLE, START, WAIT, ABORT, DONE, FAIL. Outputs are Moore-decoded from state and registers.
- IDLE: i_cfg_we latches C and R. i_req=1 moves to START and clears o_retry_cnt. If i_cfg_we and i_req are both high, config is latched first and used by that transaction.
- START: o_spi_start=1; o_ack=1 only when o_retry_cnt==0. Loads the timer with C. Next state is WAIT.
- WAIT: the timer decrements each cycle while nonzero.
  - i_spi_done=1 moves to DONE.
  - Otherwise, timer==0 with C!=0 moves to ABORT.
  - If done and expiry coincide, done wins.
  - With C==0, WAIT waits for done indefinitely.
- ABORT: o_spi_abort=1.
  - If o_retry_cnt<R, increment o_retry_cnt and go to START.
  - Otherwise go to FAIL.
- DONE: o_done=1, then IDLE. FAIL: o_fail=1, then IDLE.
- Ignored inputs:
  - i_spi_done outside WAIT.
  - i_req outside IDLE.
  - i_cfg_we outside IDLE.
- A held i_req starts a new transaction after exactly one IDLE cycle.
- o_retry_cnt holds its value in IDLE until the next accepted request.

## Timing
- Reset (i_rst_n=0 at an edge):
  - state IDLE, all pulses 0, o_busy 0, o_retry_cnt 0, C=0, R=0, timer 0, o_timeouts 0.
  - A reset mid-transfer issues no abort. The system resets the SPI core together with this block.
- Request accepted in cycle t (IDLE, i_req=1):
  - START at t+1 (o_ack, o_spi_start).
  - WAIT from t+2 with timer=C.
  - Earliest expiry is WAIT cycle t+2+C; ABORT at t+3+C.
- A timed-out attempt spans C+3 cycles (START + C+1 WAIT + ABORT). Retry START follows ABORT immediately.
- Done sampled in WAIT cycle k: o_done at k+1, IDLE at k+2.
- Pulses are registered-state decodes, never combinational from inputs.

## Configuration
- SPI_XFER_STATS_EN defined:
  - o_timeouts increments on every ABORT entry and saturates at 255.
  - Cleared by reset and by i_cfg_we in IDLE.
- Not defined:
  - No counter logic is compiled.
  - o_timeouts is tied to 0.

## Structure
- spi_ctrl_pkg holds:
  - the state enum typedef (xfer_state_t);
  - the constant STATS_W=8;
  - the saturation limit constant.
- Sub-module xfer_timer (parameter N, synchronous active-low reset):
  - ports: load strobe, load value, enable, zero flag.
  - loads on load strobe; decrements when enabled and nonzero; flags zero.
- The supervisor instantiates one xfer_timer. The FSM, config registers and stats counter live in the top level.

## Test plan
- Reset, then idle for 10 cycles -> all outputs 0, o_busy 0.
- C=3, R=0; req at t=0; i_spi_done at t=4 -> ack/start at 1, o_done at 5, IDLE at 6, o_retry_cnt=0, no abort.
- C=3, R=1; req at t=0; no done -> aborts at 6 and 12, second start at 7, o_fail at 13, o_retry_cnt=1, o_timeouts=2 (stats enabled).
- C=3; done and expiry both at t=5 -> o_done at 6, no abort.
- C=0; done at t=40 -> no abort, o_done at 41.
- Reset asserted in WAIT of the second attempt -> IDLE next cycle, all outputs 0; cfg_we in WAIT is ignored (C unchanged on the next transaction).
